// File: rtl/recursion_unit_arbiter.sv
// Round-robin front end that shares one start/ready handshaked arithmetic
// unit between NREQ requesters. Each requester keeps a one-deep request slot
// with its own operand buffer and result register.
module recursion_unit_arbiter #(
  parameter int BW          = 16,
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      ST,
  output logic [NREQ-1:0]      RD,
  input  logic [NREQ*BW-1:0]   IN0,
  input  logic [NREQ*BW-1:0]   IN1,
  output logic [NREQ*BW-1:0]   RES,
  output logic                 FU_ST,
  input  logic                 FU_RD,
  output logic [BW-1:0]        FU_IN0,
  output logic [BW-1:0]        FU_IN1,
  input  logic [BW-1:0]        FU_RES,
  output logic [IDW-1:0]       GNT,
  output logic                 BUSY,
  output logic                 ERR
);

  localparam int CW = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  state_t           state_q, state_nxt;
  logic [NREQ-1:0]  st_q;
  logic [NREQ-1:0]  pending_q;
  logic [NREQ-1:0]  new_req;
  logic [NREQ-1:0]  done_mask;
  logic [BW-1:0]    op0_buf [NREQ];
  logic [BW-1:0]    op1_buf [NREQ];
  logic [IDW-1:0]   rr_q;
  logic [IDW-1:0]   sel;
  logic             found;
  logic [CW-1:0]    cnt_q;
  logic             do_grant;
  logic             do_done;
  logic             do_timeout;

  // A requester is ready whenever it has nothing queued or in flight.
  assign RD = ~pending_q;

  // Previous ST sample; keeps running in reset so a held ST is not a new edge.
  always_ff @(posedge CLK) begin
    // NOTE: registers are always assigned with <= so every flop samples the
    // pre-edge value of every other flop, independent of process order.
    st_q <= ST;
  end

  // Per-requester new-request detect and completion mask.
  always_comb begin
    new_req   = '0;
    done_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      new_req[i]   = ST[i] & ~st_q[i] & ~pending_q[i];
      done_mask[i] = do_done && (GNT == IDW'(i));
    end
  end

  // Round-robin pick: first pending index at or above the rr pointer, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && pending_q[(int'(rr_q) + k) % NREQ]) begin
        found = 1'b1;
        sel   = IDW'((int'(rr_q) + k) % NREQ);
      end
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_nxt;
  end

  // Next-state and one-cycle action strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    state_nxt  = state_q;
    do_grant   = 1'b0;
    do_done    = 1'b0;
    do_timeout = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          do_grant  = 1'b1;
          state_nxt = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (!FU_RD) begin
          state_nxt = S_WAIT_DONE;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          do_timeout = 1'b1;
          do_done    = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (FU_RD) begin
          do_done   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture on an accepted request edge.
  always_ff @(posedge CLK) begin
    // NOTE: the operand buffers have no reset; a slot is always written on
    // request capture before the grant logic can read it.
    for (int i = 0; i < NREQ; i++) begin
      if (RST && new_req[i]) begin
        op0_buf[i] <= IN0[i*BW +: BW];
        op1_buf[i] <= IN1[i*BW +: BW];
      end
    end
  end

  // Pending slots, unit handshake, writeback and status flags.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      pending_q <= '0;
      RES       <= '0;
      FU_ST     <= 1'b0;
      FU_IN0    <= '0;
      FU_IN1    <= '0;
      GNT       <= '0;
      BUSY      <= 1'b0;
      ERR       <= 1'b0;
      rr_q      <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= (pending_q | new_req) & ~done_mask;

      if (do_grant) begin
        GNT    <= sel;
        FU_IN0 <= op0_buf[sel];
        FU_IN1 <= op1_buf[sel];
        FU_ST  <= 1'b1;
        BUSY   <= 1'b1;
        cnt_q  <= '0;
      end

      // Unit acknowledged: drop start, operands stay put until completion.
      if (state_q == S_WAIT_ACK && !FU_RD) FU_ST <= 1'b0;

      if (state_q == S_WAIT_ACK && FU_RD && !do_timeout) cnt_q <= cnt_q + 1'b1;

      if (do_timeout) ERR <= 1'b1;

      if (do_done) begin
        FU_ST <= 1'b0;
        BUSY  <= 1'b0;
        rr_q  <= (GNT == IDW'(NREQ - 1)) ? '0 : GNT + 1'b1;
      end

      for (int i = 0; i < NREQ; i++) begin
        if (done_mask[i]) RES[i*BW +: BW] <= FU_RES;
      end
    end
  end

endmodule

// File: tb/tb_recursion_unit_arbiter.sv
// Directed bench for recursion_unit_arbiter with a small multiplier model
// standing in for the shared unit.
module tb_recursion_unit_arbiter;

  localparam int BW          = 16;
  localparam int NREQ        = 4;
  localparam int IDW         = 2;
  localparam int ACK_TIMEOUT = 8;
  localparam int LAT         = 3;
  localparam logic [BW-1:0] STUCK_VAL = 16'hBEEF;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b0;
  logic [NREQ-1:0]      ST  = '0;
  logic [NREQ-1:0]      RD;
  logic [NREQ*BW-1:0]   IN0 = '0;
  logic [NREQ*BW-1:0]   IN1 = '0;
  logic [NREQ*BW-1:0]   RES;
  logic                 FU_ST;
  logic                 FU_RD;
  logic [BW-1:0]        FU_IN0;
  logic [BW-1:0]        FU_IN1;
  logic [BW-1:0]        FU_RES;
  logic [IDW-1:0]       GNT;
  logic                 BUSY;
  logic                 ERR;

  int n_tests = 0;
  int n_fail  = 0;

  logic [BW-1:0] res_model [NREQ];
  int            grant_log [$];
  int            wb_cnt    [NREQ];
  logic          fu_st_prev = 1'b0;
  logic [NREQ-1:0] rd_prev  = '1;

  bit            u_stuck = 1'b0;
  bit            u_busy;
  int            u_cnt;
  logic [BW-1:0] u_a, u_b;
  logic          u_st_q = 1'b0;

  typedef struct {
    int            idx;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic [BW-1:0] exp;
  } vec_t;

  vec_t vecs [5];

  always #5 CLK = ~CLK;

  recursion_unit_arbiter #(
    .BW(BW), .NREQ(NREQ), .IDW(IDW), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .CLK(CLK), .RST(RST), .ST(ST), .RD(RD), .IN0(IN0), .IN1(IN1), .RES(RES),
    .FU_ST(FU_ST), .FU_RD(FU_RD), .FU_IN0(FU_IN0), .FU_IN1(FU_IN1),
    .FU_RES(FU_RES), .GNT(GNT), .BUSY(BUSY), .ERR(ERR)
  );

  // Shared unit model: multiplies on a rising FU_ST, result after LAT cycles.
  // In stuck mode it never acknowledges and shows a fixed result.
  always @(posedge CLK) begin
    if (!RST) begin
      FU_RD  <= 1'b1;
      FU_RES <= '0;
      u_busy <= 1'b0;
      u_cnt  <= 0;
      u_a    <= '0;
      u_b    <= '0;
    end else if (u_stuck) begin
      FU_RES <= STUCK_VAL;
    end else if (u_busy) begin
      if (u_cnt == 0) begin
        FU_RD  <= 1'b1;
        FU_RES <= BW'(u_a * u_b);
        u_busy <= 1'b0;
      end else begin
        u_cnt <= u_cnt - 1;
      end
    end else if (FU_ST && !u_st_q) begin
      FU_RD  <= 1'b0;
      u_busy <= 1'b1;
      u_cnt  <= LAT;
      u_a    <= FU_IN0;
      u_b    <= FU_IN1;
    end
    u_st_q <= FU_ST;
  end

  // Log every job start (FU_ST rise) and every writeback (RD rise).
  always @(negedge CLK) begin
    if (RST) begin
      if (FU_ST && !fu_st_prev) grant_log.push_back(int'(GNT));
      for (int i = 0; i < NREQ; i++)
        if (RD[i] && !rd_prev[i]) wb_cnt[i]++;
    end
    fu_st_prev = FU_ST;
    rd_prev    = RD;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NREQ*BW-1:0] packed_model();
    logic [NREQ*BW-1:0] r;
    for (int i = 0; i < NREQ; i++) r[i*BW +: BW] = res_model[i];
    return r;
  endfunction

  function automatic int log_at(input int k);
    return (k < grant_log.size()) ? grant_log[k] : -1;
  endfunction

  task automatic set_ops(input int i, input logic [BW-1:0] a, input logic [BW-1:0] b);
    IN0[i*BW +: BW] = a;
    IN1[i*BW +: BW] = b;
  endtask

  task automatic wait_rd(input logic [NREQ-1:0] mask, input int budget, input string name);
    for (int c = 0; c < budget; c++) begin
      if ((RD & mask) == mask) break;
      @(negedge CLK);
    end
    check(name, RD & mask, mask);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    ST  = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < NREQ; i++) res_model[i] = '0;
  endtask

  initial begin
    int n_before;

    vecs[0] = '{0, 16'd3,      16'd4,      16'd12};
    vecs[1] = '{2, 16'h00FF,   16'h0101,   16'hFFFF};
    vecs[2] = '{3, 16'hFFFF,   16'hFFFF,   16'h0001};
    vecs[3] = '{1, 16'h1000,   16'h0010,   16'h0000};
    vecs[4] = '{0, 16'h0000,   16'h1234,   16'h0000};
    for (int i = 0; i < NREQ; i++) begin
      res_model[i] = '0;
      wb_cnt[i]    = 0;
    end

    // Reset state.
    repeat (3) @(negedge CLK);
    check("rst_rd",    RD,     4'hF);
    check("rst_res",   RES,    64'h0);
    check("rst_fu_st", FU_ST,  1'b0);
    check("rst_fu_in0", FU_IN0, 16'h0);
    check("rst_fu_in1", FU_IN1, 16'h0);
    check("rst_gnt",   GNT,    2'd0);
    check("rst_busy",  BUSY,   1'b0);
    check("rst_err",   ERR,    1'b0);
    RST = 1'b1;

    // Single-request vectors, one at a time.
    foreach (vecs[v]) begin
      @(negedge CLK);
      set_ops(vecs[v].idx, vecs[v].a, vecs[v].b);
      ST[vecs[v].idx] = 1'b1;
      @(negedge CLK);
      ST[vecs[v].idx] = 1'b0;
      check("vec_rd_low",   RD[vecs[v].idx], 1'b0);
      check("vec_st_early", FU_ST, 1'b0);
      @(negedge CLK);
      check("vec_fu_st",  FU_ST,  1'b1);
      check("vec_fu_in0", FU_IN0, vecs[v].a);
      check("vec_fu_in1", FU_IN1, vecs[v].b);
      check("vec_gnt",    GNT,    vecs[v].idx);
      check("vec_busy",   BUSY,   1'b1);
      res_model[vecs[v].idx] = vecs[v].exp;
      wait_rd(4'hF, 40, "vec_done");
      check("vec_res",     RES,    packed_model());
      check("vec_idle",    BUSY,   1'b0);
      check("vec_err",     ERR,    1'b0);
      check("vec_in_hold", FU_IN0, vecs[v].a);
    end

    // All four requesters start on the same edge.
    do_reset();
    grant_log.delete();
    @(negedge CLK);
    set_ops(0, 16'd2, 16'd5);
    set_ops(1, 16'd3, 16'd3);
    set_ops(2, 16'd7, 16'd1);
    set_ops(3, 16'd0, 16'd9);
    ST = 4'hF;
    @(negedge CLK);
    ST = '0;
    wait_rd(4'hF, 200, "all4_done");
    check("all4_njobs", grant_log.size(), 4);
    for (int k = 0; k < 4; k++) check("all4_order", log_at(k), k);
    res_model[0] = 16'd10;
    res_model[1] = 16'd9;
    res_model[2] = 16'd7;
    res_model[3] = 16'd0;
    check("all4_res", RES, packed_model());

    // Fairness: requester 0 re-requests right after completing while 2 waits.
    do_reset();
    grant_log.delete();
    @(negedge CLK);
    set_ops(0, 16'd2, 16'd2);
    set_ops(2, 16'd4, 16'd4);
    ST = 4'b0101;
    @(negedge CLK);
    ST = '0;
    wait_rd(4'b0001, 40, "fair_first");
    set_ops(0, 16'd5, 16'd5);
    ST[0] = 1'b1;
    @(negedge CLK);
    ST[0] = 1'b0;
    wait_rd(4'hF, 100, "fair_done");
    check("fair_njobs", grant_log.size(), 3);
    check("fair_g0", log_at(0), 0);
    check("fair_g1", log_at(1), 2);
    check("fair_g2", log_at(2), 0);
    res_model[0] = 16'd25;
    res_model[2] = 16'd16;
    check("fair_res", RES, packed_model());

    // Second ST edge on requester 1 while busy is ignored.
    grant_log.delete();
    for (int i = 0; i < NREQ; i++) wb_cnt[i] = 0;
    @(negedge CLK);
    set_ops(1, 16'd11, 16'd13);
    ST[1] = 1'b1;
    @(negedge CLK);
    ST[1] = 1'b0;
    @(negedge CLK);
    set_ops(1, 16'd99, 16'd99);
    ST[1] = 1'b1;
    @(negedge CLK);
    ST[1] = 1'b0;
    check("tog_rd_low",  RD[1],  1'b0);
    check("tog_in_hold", FU_IN0, 16'd11);
    wait_rd(4'b0010, 40, "tog_done");
    check("tog_res", RES[1*BW +: BW], 16'd143);
    repeat (12) @(negedge CLK);
    check("tog_njobs", grant_log.size(), 1);
    check("tog_nwb",   wb_cnt[1], 1);
    check("tog_rd",    RD, 4'hF);

    // Unit never acknowledges: timeout, then the next request still runs.
    grant_log.delete();
    u_stuck = 1'b1;
    @(negedge CLK);
    set_ops(1, 16'd5, 16'd5);
    ST[1] = 1'b1;
    @(negedge CLK);
    ST[1] = 1'b0;
    @(negedge CLK);
    check("to_fu_st", FU_ST, 1'b1);
    set_ops(3, 16'd6, 16'd7);
    ST[3] = 1'b1;
    @(negedge CLK);
    ST[3] = 1'b0;
    repeat (6) @(negedge CLK);
    check("to_err_pre",   ERR,   1'b0);
    check("to_st_pre",    FU_ST, 1'b1);
    check("to_busy_pre",  BUSY,  1'b1);
    @(negedge CLK);
    check("to_err",   ERR,   1'b1);
    check("to_st",    FU_ST, 1'b0);
    check("to_rd",    RD[1], 1'b1);
    check("to_res",   RES[1*BW +: BW], STUCK_VAL);
    u_stuck = 1'b0;
    wait_rd(4'b1000, 60, "to_next_done");
    check("to_next_res", RES[3*BW +: BW], 16'd42);
    check("to_err_sticky", ERR, 1'b1);
    check("to_log0", log_at(0), 1);
    check("to_log1", log_at(1), 3);

    // Reset while the job waits for completion.
    @(negedge CLK);
    set_ops(2, 16'd9, 16'd9);
    ST[2] = 1'b1;
    @(negedge CLK);
    ST[2] = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (BUSY && !FU_ST) break;
      @(negedge CLK);
    end
    check("mid_in_done_wait", {BUSY, FU_ST}, 2'b10);
    n_before = grant_log.size();
    RST = 1'b0;
    @(negedge CLK);
    check("mid_rd",    RD,    4'hF);
    check("mid_res",   RES,   64'h0);
    check("mid_fu_st", FU_ST, 1'b0);
    check("mid_busy",  BUSY,  1'b0);
    check("mid_err",   ERR,   1'b0);
    RST = 1'b1;
    repeat (10) @(negedge CLK);
    check("mid_res_late", RES, 64'h0);
    check("mid_rd_late",  RD,  4'hF);
    check("mid_no_job",   grant_log.size(), n_before);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/recursion_unit_arbiter.md
Name: recursion_unit_arbiter

Overview:
- Shares one ST/RD-handshaked arithmetic unit (for example the 16-bit recursive multiplication composition) between NREQ requesters.
- Each requester sees the same start/ready protocol as the unit itself, so the arbiter is a drop-in front end.
- Requests are queued per requester, granted round-robin, and executed one at a time.
- Each result is written back into that requester's own result register.

Parameters:
- BW, 16, operand/result bit width.
- NREQ, 4, number of requesters.
- IDW, 2, width of the grant index (at least ceil(log2(NREQ))).
- ACK_TIMEOUT, 8, max cycles to wait for FU_RD to fall after FU_ST is raised.

Ports:
- CLK  in  1  clock, all logic on posedge.
- RST  in  1  synchronous reset, active-low (0 = reset).
- ST  in  NREQ  per-requester start; the rising edge posts a request.
- RD  out  NREQ  per-requester ready; 1 = idle/result valid, 0 = request pending or in flight.
- IN0  in  NREQ*BW  per-requester operand 0; slice i = bits [i*BW +: BW].
- IN1  in  NREQ*BW  per-requester operand 1, same packing.
- RES  out  NREQ*BW  per-requester result register, same packing.
- FU_ST  out  1  start to the shared unit.
- FU_RD  in  1  ready from the shared unit.
- FU_IN0  out  BW  operand 0 to the shared unit.
- FU_IN1  out  BW  operand 1 to the shared unit.
- FU_RES  in  BW  result from the shared unit.
- GNT  out  IDW  index of the requester currently or last served.
- BUSY  out  1  1 while a job is in flight (states WAIT_ACK/WAIT_DONE).
- ERR  out  1  sticky handshake-timeout flag.

Behaviour:
- Reset (RST==0 at a posedge): RD all 1, RES all 0, FU_ST 0, FU_IN0/FU_IN1 0, GNT 0, BUSY 0, ERR 0, all pending bits 0, rr pointer 0, state IDLE.
- Reset mid-job discards the job with no writeback. The integrator resets the shared unit in the same cycle.
- Request capture, per requester i, every cycle, independent of state:
  - If ST[i]==1, ST[i] was 0 on the previous edge, and RD[i]==1: set pending[i]=1, set RD[i]=0, and latch IN0/IN1 slice i into the operand buffer i.
  - Edges arriving while RD[i]==0 are ignored; no queueing deeper than one per requester.
  - The ST edge detector runs during reset too, so an ST held high through reset is not a new edge.
- State IDLE: if any pending bit is set, choose the first pending index searching from the rr pointer upward, modulo NREQ. On that edge:
  - GNT<=g, FU_IN0/FU_IN1 <= buffer g, FU_ST<=1, BUSY<=1, timeout counter<=0.
  - Go to WAIT_ACK.
  - A request captured on the same edge is not eligible until the next cycle.
- State WAIT_ACK (FU_ST held 1, operands held):
  - If FU_RD==0: FU_ST<=0, go to WAIT_DONE.
  - Else if counter==ACK_TIMEOUT-1: ERR<=1, FU_ST<=0, then complete exactly as in WAIT_DONE, capturing FU_RES.
  - Otherwise increment the counter.
- State WAIT_DONE (FU_ST 0, FU_IN0/FU_IN1 held stable until completion):
  - On FU_RD==1: RES slice g <= FU_RES, RD[g]<=1, pending[g]<=0, rr pointer <= (g+1) mod NREQ, BUSY<=0, go to IDLE.
  - FU_RES must not be sampled earlier than this.
- Latency:
  - ST[i] edge sampled at edge t: FU_ST=1 at t+1 at the earliest.
  - Result written and RD[i]=1 on the edge after the one where FU_RD returns to 1 is sampled.
- FU_ST is low for at least one cycle between consecutive jobs, so the unit always sees a fresh rising edge.
- Same-requester re-request in the completion cycle is ignored, because RD[g] is still 0 at that edge.
- Completion of g and a new request from j!=g on the same edge: both take effect; j is eligible in the next IDLE cycle.
- FU_IN0/FU_IN1 keep their last value while idle.
- ERR clears only on reset.
- Widths: no arithmetic on data; the counter is ceil(log2(ACK_TIMEOUT))+1 bits.

Test Plan:
- Single request, unit computes IN0*IN1: requester 0 sends 3,4 → FU_ST pulse, FU_IN0=3/FU_IN1=4, RES[0]=12, RD[0] back to 1, GNT=0, ERR=0.
- All four ST rise on the same edge with operand pairs (2,5),(3,3),(7,1),(0,9) → served in order 0,1,2,3, RES = 10,9,7,0, FU_ST low ≥1 cycle between jobs.
- Fairness: requester 0 re-requests immediately after each completion while requester 2 is pending → grants alternate 0,2,0, never 0,0.
- ST[1] toggled again while RD[1]==0 → ignored, exactly one job and one writeback for requester 1; buffered operands unchanged.
- Unit model never drops FU_RD → after ACK_TIMEOUT=8 cycles ERR=1, FU_ST=0, RD[i]=1 with RES[i]=FU_RES, next pending request still served.
- RST driven 0 while in WAIT_DONE → next edge: RD=4'b1111, RES all 0, FU_ST=0, BUSY=0, no late writeback when FU_RD later rises.
